// File: rtl/fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter_if
// Brief    : Producer / FIFO-write-side bundle for fifo_push_arbiter.
//            slave = arbiter side, master = producers plus FIFO side.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_push_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int c_OW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data;
    logic [N_REQ-1:0]    ack;
    logic [c_OW-1:0]     owner;
    logic                busy;
    logic [DW-1:0]       fifo_data_in;
    logic                fifo_push;
    logic                fifo_full;

    modport master (
        output req, data, fifo_full,
        input  ack, owner, busy, fifo_data_in, fifo_push
    );

    modport slave (
        input  req, data, fifo_full,
        output ack, owner, busy, fifo_data_in, fifo_push
    );
endinterface
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO push port among
//            N_REQ producers. Optional FIFO_ARB_STATS_EN adds push/stall
//            counters.
// Revision : 1.0  initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_push_arbiter_if.slave bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]        push_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    localparam int c_OW = $clog2(N_REQ);
    localparam int c_CW = $clog2(BURST_LEN + 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_BURST = 1'b1;

    logic [0:0]      r_state;
    logic [c_OW-1:0] r_owner;
    logic [c_OW-1:0] r_last;
    logic [c_CW-1:0] r_cnt;

    logic [DW-1:0]   w_data_arr [N_REQ];
    logic [c_OW-1:0] w_cand     [N_REQ];
    logic [c_OW-1:0] w_winner;
    logic            w_found;
    logic            w_busy;
    logic            w_own_req;
    logic            w_push;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_data_arr[g] = bus.data[g*DW +: DW];
        end
    endgenerate

    // Candidates in priority order, starting just after the previous winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand[k] = c_OW'((int'(r_last) + k + 1) % N_REQ);
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    assign w_busy    = (r_state == c_S_BURST);
    assign w_own_req = bus.req[r_owner];
    assign w_push    = w_busy & w_own_req & ~bus.fifo_full;

    assign bus.fifo_push    = w_push;
    assign bus.ack          = w_push ? (N_REQ'(1) << r_owner) : '0;
    assign bus.fifo_data_in = w_busy ? w_data_arr[r_owner] : '0;
    assign bus.owner        = r_owner;
    assign bus.busy         = w_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
            r_owner <= '0;
            r_last  <= c_OW'(N_REQ - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_state <= c_S_BURST;
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                c_S_BURST: begin
                    // A full FIFO with the owner still requesting holds the grant.
                    if (w_push) begin
                        if (r_cnt == c_CW'(BURST_LEN - 1)) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (!w_own_req) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_push_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_push_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_push_cnt <= r_push_cnt + 16'd1;
            end
            if (w_busy && w_own_req && bus.fifo_full) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign push_cnt  = r_push_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    // Statistics counters not built.
`endif
endmodule
`default_nettype wire

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write-side arbiter that shares the single push port of `fifo_wrapper` among `N_REQ` producers. Sits in the write clock domain, directly in front of the FIFO's `data_in`/`push`/`full` pins. It grants one producer at a time for a bounded burst, so producers are not starved and words from one burst stay contiguous in the FIFO.

## Interface
Parameters:
- `N_REQ`, 4: number of producers, 2..8.
- `DW`, 8: data width; must match the FIFO data width.
- `BURST_LEN`, 4: maximum words pushed per grant, 1..16.

Ports:
- `clk`  in  1  single clock, the FIFO write clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-producer request. Level, held while the producer has a word ready.
- `data`  in  N_REQ*DW  per-producer word. Producer i uses bits `[i*DW +: DW]`.
- `ack`  out  N_REQ  one-hot. The word of producer i is consumed this cycle.
- `owner`  out  $clog2(N_REQ)  index of the current grant holder. Valid while `busy`=1.
- `busy`  out  1  a grant is active (state BURST).
- `fifo_data_in`  out  DW  to FIFO `data_in`.
- `fifo_push`  out  1  to FIFO `push`.
- `fifo_full`  in  1  from FIFO `full`.

## Operation
- State machine has two states.
  - IDLE:
    - If no `req` bit is set, stay in IDLE.
    - Otherwise, search from `(last+1) mod N_REQ` upward with wrap-around. The first set `req` bit wins.
    - Load `owner` and `last` with the winner, clear `cnt`, and go to BURST.
    - No push occurs in IDLE.
  - BURST:
    - `fifo_push = req[owner] & ~fifo_full`. `ack[owner] = fifo_push`. All other `ack` bits are 0.
    - `fifo_data_in = data[owner]`, driven continuously while in BURST.
    - `cnt` increments on each push. `cnt` is a $clog2(BURST_LEN+1)-bit counter.
    - Return to IDLE when either condition holds:
      - `req[owner]`=0, with no push that cycle.
      - A push occurs with `cnt == BURST_LEN-1`.
    - If `fifo_full`=1 and `req[owner]`=1, stay in BURST. `cnt` holds and there is no push (stall). The grant is not revoked while full.
- `last` records the most recent winner, so a producer cannot win twice in a row if others are requesting.
- A producer may drop `req` mid-burst. The grant ends and that producer's next request re-arbitrates normally.
- `req` bits of non-owners are ignored during BURST.
- `data` may change every cycle. Only the owner's word is sampled, and only when `ack` is high.

## Timing
- Reset (`rst`=0 at a clock edge):
  - state = IDLE, `last` = N_REQ-1 (producer 0 wins first), `cnt` = 0, `owner` = 0.
  - `busy`, `ack`, and `fifo_push` are 0. `fifo_data_in` = 0.
  - Reset mid-burst aborts the burst. A word acked in the same cycle as reset is still pushed, because push is combinational.
- Arbitration latency: 1 cycle. `req` rises in cycle t (IDLE), BURST starts in t+1, and the first push is possible in t+1.
- Push path is combinational from `req`, `fifo_full` and state, with zero latency. `fifo_full` sampled in cycle t gates the push in cycle t.
- Gap between bursts: exactly 1 IDLE cycle.
- Back-to-back pushes within a burst: 1 word per cycle when not full.
- `owner` and `busy` are registered and change only at clock edges.

## Configuration
- `FIFO_ARB_STATS_EN` defined: adds two outputs.
  - `push_cnt` (16-bit): counts every `fifo_push`.
  - `stall_cnt` (16-bit): counts BURST cycles with `req[owner] & fifo_full`.
  - Both wrap modulo 2^16 and reset to 0.
- Not defined: both ports and all associated logic are absent. Core behaviour is identical.

## Test plan
- Single producer 0 holds `req` for 10 words with FIFO never full:
  - 4 pushes, 1 IDLE cycle, 4 pushes, 1 IDLE cycle, 2 pushes.
  - `ack[0]` pattern is 1111_0_1111_0_11 starting the cycle after `req` rises.
- All 4 producers request continuously, each `data` = producer index:
  - FIFO receives 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…
  - Never two consecutive grants to the same producer.
- `fifo_full` forced high for 3 cycles mid-burst after 2 words:
  - `fifo_push`=0 for those 3 cycles, `owner` unchanged, `cnt` holds at 2.
  - Remaining 2 words are pushed after `full` drops. With stats enabled, `stall_cnt`=3.
- Producer 2 drops `req` after 1 word while producer 3 is requesting:
  - Burst ends after 1 push, 1 IDLE cycle, then producer 3 is granted.
- `rst`=0 asserted for 1 cycle during a burst:
  - Next cycle `busy`=0 and `ack`=0.
  - With `req`=4'b0011, producer 0 is granted first after reset.
- Throughput check with `fifo_wrapper` connected, 21 words from 3 producers:
  - Popped sequence equals the pushed sequence.
  - No push occurs while `full`=1.
